// File: rtl/lsu_rmw.sv
// Load/store unit for a word-wide data memory with byte and half stores done
// as read-modify-write. Handles RV32I sizes with sign/zero extension and request checks.
module lsu_rmw #(
  parameter int unsigned WORD_AW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        rdata,
  output logic               mem_we,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [31:0]        mem_wd,
  input  logic [31:0]        mem_rd
);

  localparam int unsigned DW      = 32;
  localparam int unsigned HI_BITS = WORD_AW + 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    STORE  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t        state, state_d;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [DW-1:0] wdata_q;

  logic          req_bad_c;
  logic [DW-1:0] load_ext_c;
  logic [DW-1:0] merge_c;
  logic [7:0]    sel_b_c;
  logic [15:0]   sel_h_c;

  // Request legality: size code, alignment and address range.
  always_comb begin
    req_bad_c = 1'b0;
    unique case (req_funct3)
      3'b000:         req_bad_c = 1'b0;
      3'b001:         req_bad_c = req_addr[0];
      3'b010:         req_bad_c = (req_addr[1:0] != 2'b00);
      3'b100:         req_bad_c = req_we;
      3'b101:         req_bad_c = req_we | req_addr[0];
      default:        req_bad_c = 1'b1;
    endcase
    if ((req_addr >> HI_BITS) != '0) req_bad_c = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    sel_b_c = mem_rd[{off_q, 3'b000} +: 8];
    sel_h_c = mem_rd[{off_q[1], 4'b0000} +: 16];
    unique case (f3_q[1:0])
      2'b00:   load_ext_c = f3_q[2] ? {24'b0, sel_b_c} : {{24{sel_b_c[7]}}, sel_b_c};
      2'b01:   load_ext_c = f3_q[2] ? {16'b0, sel_h_c} : {{16{sel_h_c[15]}}, sel_h_c};
      default: load_ext_c = mem_rd;
    endcase
    merge_c = mem_rd;
    if (f3_q[1:0] == 2'b00) merge_c[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                    merge_c[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad_c)                 state_d = ERR;
          else if (!req_we)              state_d = LOAD;
          else if (req_funct3 == 3'b010) state_d = STORE;
          else                           state_d = RMW_RD;
        end
      end
      LOAD:    state_d = DONE;
      RMW_RD:  state_d = STORE;
      STORE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      rdata    <= '0;
      f3_q     <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state  <= state_d;
      busy   <= (state_d != IDLE);
      done   <= (state_d == DONE) || (state_d == ERR);
      err    <= (state_d == ERR);
      mem_we <= (state_d == STORE);
      if (state == IDLE && req_valid) begin
        f3_q     <= req_funct3;
        off_q    <= req_addr[1:0];
        wdata_q  <= req_wdata;
        mem_addr <= req_addr[WORD_AW+1:2];
        if (state_d == STORE) mem_wd <= req_wdata;
      end
      if (state == RMW_RD) mem_wd <= merge_c;
      if (state == LOAD)   rdata  <= load_ext_c;
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a small behavioural word memory.
module tb_lsu_rmw;

  localparam int unsigned WORD_AW = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_we = 1'b0;
  logic [2:0]         req_funct3 = 3'b000;
  logic [31:0]        req_addr = '0;
  logic [31:0]        req_wdata = '0;
  logic               busy, done, err, mem_we;
  logic [31:0]        rdata, mem_wd, mem_rd;
  logic [WORD_AW-1:0] mem_addr;

  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  int          we_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  lsu_rmw #(.WORD_AW(WORD_AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wd;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Issue one request from IDLE; report done latency, mem_we cycle and err.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output int we_at,
                        output logic e);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    we_at = 0;
    while (!done && lat < 10) begin
      if (mem_we && we_at == 0) we_at = lat;
      @(posedge clk);
      #1 lat++;
    end
    if (lat >= 10) check("done_timeout", 32'(lat), 32'd0);
    e = err;
    @(posedge clk);
    #1;
  endtask

  int   lat, we_at, w0, dn, dn_err;
  logic e;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    rst = 1'b0;

    poke(8'd7, 32'h1122_3344);
    poke(8'd8, 32'h0000_0080);

    do_req(1'b0, 3'b000, 32'h1F, 32'h0, lat, we_at, e);
    check("lb_lat", 32'(lat), 32'd2);
    check("lb_err", 32'(e), 32'd0);
    check("lb_rdata", rdata, 32'h0000_0011);
    do_req(1'b0, 3'b100, 32'h20, 32'h0, lat, we_at, e);
    check("lbu_rdata", rdata, 32'h0000_0080);
    do_req(1'b0, 3'b000, 32'h20, 32'h0, lat, we_at, e);
    check("lb_neg_rdata", rdata, 32'hFFFF_FF80);

    w0 = we_cnt;
    do_req(1'b1, 3'b000, 32'h1D, 32'hAB, lat, we_at, e);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_we_at", 32'(we_at), 32'd2);
    check("sb_we_cnt", 32'(we_cnt - w0), 32'd1);
    check("sb_word", mem[7], 32'h1122_AB44);
    check("sb_rdata_kept", rdata, 32'hFFFF_FF80);

    do_req(1'b1, 3'b001, 32'h7A, 32'hBEEF, lat, we_at, e);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_word", mem[30], 32'hBEEF_0000);
    do_req(1'b0, 3'b001, 32'h7A, 32'h0, lat, we_at, e);
    check("lh_rdata", rdata, 32'hFFFF_BEEF);
    do_req(1'b0, 3'b101, 32'h7A, 32'h0, lat, we_at, e);
    check("lhu_rdata", rdata, 32'h0000_BEEF);

    do_req(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, lat, we_at, e);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_we_at", 32'(we_at), 32'd1);
    check("sw_word", mem[16], 32'hCAFE_F00D);
    do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, we_at, e);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", rdata, 32'hCAFE_F00D);

    w0 = we_cnt;
    do_req(1'b0, 3'b010, 32'h06, 32'h0, lat, we_at, e);
    check("lw_mis_lat", 32'(lat), 32'd1);
    check("lw_mis_err", 32'(e), 32'd1);
    do_req(1'b0, 3'b010, 32'h0004_0000, 32'h0, lat, we_at, e);
    check("lw_range_err", 32'(e), 32'd1);
    do_req(1'b0, 3'b011, 32'h0, 32'h0, lat, we_at, e);
    check("f3_011_err", 32'(e), 32'd1);
    do_req(1'b1, 3'b100, 32'h1C, 32'h55, lat, we_at, e);
    check("sbu_err", 32'(e), 32'd1);
    do_req(1'b1, 3'b001, 32'h1D, 32'h55, lat, we_at, e);
    check("sh_mis_err", 32'(e), 32'd1);
    check("err_no_write", 32'(we_cnt - w0), 32'd0);
    check("err_rdata_kept", rdata, 32'hCAFE_F00D);
    check("err_word_kept", mem[7], 32'h1122_AB44);

    // Reset while the SW is in STORE.
    poke(8'd17, 32'h0000_0055);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h44; req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("store_we_high", 32'(mem_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_store_we", 32'(mem_we), 32'd0);
    check("rst_store_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("rst_store_done", 32'(done), 32'd0);
    check("rst_store_word", mem[17], 32'h0000_0055);
    rst = 1'b0;
    do_req(1'b0, 3'b010, 32'h44, 32'h0, lat, we_at, e);
    check("post_rst_lat", 32'(lat), 32'd2);
    check("post_rst_rdata", rdata, 32'h0000_0055);

    // req_valid held high: LW takes IDLE, LOAD, DONE -> one accept per 3 edges.
    dn = 0;
    dn_err = 0;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1C;
    req_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
      if (done && err) dn_err++;
    end
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("stream_dones", 32'(dn), 32'd10);
    check("stream_errs", 32'(dn_err), 32'd0);
    check("stream_idle", 32'(busy), 32'd0);
    check("stream_rdata", rdata, 32'h1122_AB44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
